// File: rtl/pipe_credit_skid_buffer_pkg.sv
// rtl/pipe_credit_skid_buffer_pkg.sv - sizing helpers and shared types for the credit skid buffer
package pipe_credit_pkg;

  // Occupancy and in-flight counters must be able to hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic issue_bad;
    logic orphan;
    logic drop;
  } err_evt_t;

endpackage

// File: rtl/pipe_credit_skid_buffer_if.sv
// rtl/pipe_credit_skid_buffer_if.sv - producer credit, pipeline exit and consumer handshake bundle
interface pipe_credit_skid_buffer_if
  import pipe_credit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = cnt_w(DEPTH);

  logic              issue_ready_o;
  logic              issue_i;
  logic              data_valid_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic [CNT_W-1:0]  count_o;
  logic              err_o;

  modport slave (
    input  issue_i, data_valid_i, data_i, ready_i,
    output issue_ready_o, valid_o, data_o, count_o, err_o
  );

  modport master (
    output issue_i, data_valid_i, data_i, ready_i,
    input  issue_ready_o, valid_o, data_o, count_o, err_o
  );
endinterface

// File: rtl/pipe_credit_skid_buffer_mem.sv
// rtl/pipe_credit_skid_buffer_mem.sv - unreset ring storage, one write port and one async read port
module ring_buffer_mem
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [PTR_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [PTR_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pipe_credit_skid_buffer.sv
// rtl/pipe_credit_skid_buffer.sv - credit-issuing skid buffer behind a fixed-latency, non-stallable pipeline
module pipe_credit_skid_buffer
  import pipe_credit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int DEPTH      = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  pipe_credit_skid_buffer_if.slave bus
);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_inflight;
  logic              r_err;

  logic [CNT_W:0]    w_credit_sum;
  logic              w_issue_ready;
  logic              w_issue_ok;
  logic              w_arrive_ok;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  err_evt_t          w_err_evt;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CNT_W-1:0]  w_inflight_nxt;
  logic [DATA_W-1:0] w_head;

  // Credits come only from registered state, so a pop returns its credit a cycle later.
  assign w_credit_sum  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_issue_ready = w_credit_sum < {1'b0, DEPTH_C};

  assign w_issue_ok  = bus.issue_i && w_issue_ready;
  assign w_arrive_ok = bus.data_valid_i && (r_inflight != '0);
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && bus.ready_i;
  assign w_push      = bus.data_valid_i && ((r_count < DEPTH_C) || w_pop);

  assign w_err_evt.issue_bad = bus.issue_i && !w_issue_ready;
  assign w_err_evt.orphan    = bus.data_valid_i && (r_inflight == '0);
  assign w_err_evt.drop      = bus.data_valid_i && !w_push;

  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_ONE;
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_ONE;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // An orphan arrival never decrements, so the counter cannot underflow.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_issue_ok && !w_arrive_ok) begin
      w_inflight_nxt = r_inflight + CNT_ONE;
    end else if (w_arrive_ok && !w_issue_ok) begin
      w_inflight_nxt = r_inflight - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      if (|w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  ring_buffer_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign bus.issue_ready_o = w_issue_ready;
  assign bus.valid_o       = w_valid;
  assign bus.data_o        = w_head;
  assign bus.count_o       = r_count;
  assign bus.err_o         = r_err;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= DEPTH_C);

  // A well-behaved producer never has more than PIPE_DEPTH words between issue and arrival.
  a_inflight_latency : assert property (@(posedge clk) disable iff (!rst_n || r_err)
    int'(r_inflight) <= PIPE_DEPTH);
endmodule

// File: tb/tb_pipe_credit_skid_buffer.sv
// tb/tb_pipe_credit_skid_buffer.sv - directed bench for pipe_credit_skid_buffer
module tb_pipe_credit_skid_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_credit_skid_buffer_if #(.DATA_W(8), .DEPTH(5)) d5_if ();
  pipe_credit_skid_buffer_if #(.DATA_W(8), .DEPTH(4)) d4_if ();
  pipe_credit_skid_buffer_if #(.DATA_W(8), .DEPTH(3)) d3_if ();
  pipe_credit_skid_buffer_if #(.DATA_W(8), .DEPTH(1)) d1_if ();

  pipe_credit_skid_buffer #(.DATA_W(8), .PIPE_DEPTH(3), .DEPTH(5)) u_d5 (.clk(clk), .rst_n(rst_n), .bus(d5_if));
  pipe_credit_skid_buffer #(.DATA_W(8), .PIPE_DEPTH(1), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(d4_if));
  pipe_credit_skid_buffer #(.DATA_W(8), .PIPE_DEPTH(1), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(d3_if));
  pipe_credit_skid_buffer #(.DATA_W(8), .PIPE_DEPTH(1), .DEPTH(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(d1_if));

  // Upstream pipelines: carry credited words with exactly PIPE_DEPTH cycles of latency.
  logic [7:0] d5_src, d4_src, d3_src, d1_src;
  logic [2:0] d5_pv;
  logic [7:0] d5_pd [3];
  logic       d4_pv, d3_pv, d1_pv;
  logic [7:0] d4_pd, d3_pd, d1_pd;
  logic       d4_inj_v, d3_inj_v;
  logic [7:0] d4_inj_d, d3_inj_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d5_pv <= '0;
      d4_pv <= 1'b0;
      d3_pv <= 1'b0;
      d1_pv <= 1'b0;
    end else begin
      d5_pv    <= {d5_pv[1:0], d5_if.issue_i && d5_if.issue_ready_o};
      d5_pd[2] <= d5_pd[1];
      d5_pd[1] <= d5_pd[0];
      d5_pd[0] <= d5_src;
      d4_pv    <= d4_if.issue_i && d4_if.issue_ready_o;
      d4_pd    <= d4_src;
      d3_pv    <= d3_if.issue_i && d3_if.issue_ready_o;
      d3_pd    <= d3_src;
      d1_pv    <= d1_if.issue_i && d1_if.issue_ready_o;
      d1_pd    <= d1_src;
    end
  end

  assign d5_if.data_valid_i = d5_pv[2];
  assign d5_if.data_i       = d5_pd[2];
  assign d4_if.data_valid_i = d4_pv | d4_inj_v;
  assign d4_if.data_i       = d4_inj_v ? d4_inj_d : d4_pd;
  assign d3_if.data_valid_i = d3_pv | d3_inj_v;
  assign d3_if.data_i       = d3_inj_v ? d3_inj_d : d3_pd;
  assign d1_if.data_valid_i = d1_pv;
  assign d1_if.data_i       = d1_pd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int         acc, rcv, first_v, rdy_drop, n;
  logic [7:0] wd, exp_d;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    d5_if.issue_i = 1'b0; d5_if.ready_i = 1'b0; d5_src = '0;
    d4_if.issue_i = 1'b0; d4_if.ready_i = 1'b0; d4_src = '0;
    d3_if.issue_i = 1'b0; d3_if.ready_i = 1'b0; d3_src = '0;
    d1_if.issue_i = 1'b0; d1_if.ready_i = 1'b0; d1_src = '0;
    d4_inj_v = 1'b0; d4_inj_d = '0;
    d3_inj_v = 1'b0; d3_inj_d = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(d4_if.valid_o), 32'd0);
    check("rst_count", 32'(d4_if.count_o), 32'd0);
    check("rst_issue_ready", 32'(d4_if.issue_ready_o), 32'd1);
    check("rst_err", 32'(d4_if.err_o), 32'd0);

    // Streaming through a 3-stage pipe into DEPTH=5.
    first_v = -1; rcv = 0; rdy_drop = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      d5_if.issue_i = (c < 16);
      d5_src = 8'(16 + c);
      d5_if.ready_i = 1'b1;
      @(negedge clk);
      if (c < 16 && !d5_if.issue_ready_o) rdy_drop++;
      if (d5_if.valid_o) begin
        if (first_v < 0) first_v = c;
        check("stream_data", 32'(d5_if.data_o), 32'(16 + rcv));
        rcv++;
      end
      @(posedge clk); #1;
    end
    d5_if.issue_i = 1'b0;
    d5_if.ready_i = 1'b0;
    check("stream_first_valid", 32'(first_v), 32'd4);
    check("stream_words", 32'(rcv), 32'd16);
    check("stream_issue_ready_drops", 32'(rdy_drop), 32'd0);
    check("stream_err", 32'(d5_if.err_o), 32'd0);

    // Backpressure on DEPTH=4.
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      d4_if.issue_i = d4_if.issue_ready_o;
      d4_src = 8'(8'h40 + acc);
      if (d4_if.issue_ready_o) acc++;
      @(posedge clk); #1;
    end
    d4_if.issue_i = 1'b0;
    @(negedge clk);
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_issue_ready", 32'(d4_if.issue_ready_o), 32'd0);
    check("bp_count", 32'(d4_if.count_o), 32'd4);
    check("bp_err", 32'(d4_if.err_o), 32'd0);

    // Protocol errors while full.
    @(posedge clk); #1; d4_if.issue_i = 1'b1;
    @(posedge clk); #1; d4_if.issue_i = 1'b0;
    @(negedge clk);
    check("err_after_bad_issue", 32'(d4_if.err_o), 32'd1);
    check("err_inflight_kept", 32'(u_d4.r_inflight), 32'd0);
    @(posedge clk); #1; d4_inj_v = 1'b1; d4_inj_d = 8'hEE;
    @(posedge clk); #1; d4_inj_v = 1'b0;
    @(negedge clk);
    check("err_drop_count", 32'(d4_if.count_o), 32'd4);
    check("err_sticky", 32'(d4_if.err_o), 32'd1);

    @(posedge clk); #1; d4_if.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(d4_if.valid_o), 32'd1);
      check("drain_data", 32'(d4_if.data_o), 32'(8'h40 + i));
      if (i == 0) check("drain_ready_before_pop", 32'(d4_if.issue_ready_o), 32'd0);
      if (i == 1) check("drain_ready_after_pop", 32'(d4_if.issue_ready_o), 32'd1);
      @(posedge clk); #1;
    end
    d4_if.ready_i = 1'b0;
    @(negedge clk);
    check("drain_empty_valid", 32'(d4_if.valid_o), 32'd0);
    check("drain_empty_count", 32'(d4_if.count_o), 32'd0);

    // Full push+pop with pointer wrap on DEPTH=3.
    @(posedge clk); #1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      d3_if.issue_i = d3_if.issue_ready_o;
      d3_src = 8'(8'h30 + acc);
      if (d3_if.issue_ready_o) acc++;
      @(posedge clk); #1;
    end
    d3_if.issue_i = 1'b0;
    @(negedge clk);
    check("wrap_fill_count", 32'(d3_if.count_o), 32'd3);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      d3_if.ready_i = 1'b1;
      d3_inj_v = 1'b1;
      d3_inj_d = 8'(8'h80 + i);
      exp_d = (i < 3) ? 8'(8'h30 + i) : 8'(8'h80 + i - 3);
      @(negedge clk);
      check("wrap_count", 32'(d3_if.count_o), 32'd3);
      check("wrap_data", 32'(d3_if.data_o), 32'(exp_d));
      @(posedge clk); #1;
    end
    d3_if.ready_i = 1'b0;
    d3_inj_v = 1'b0;

    // Asynchronous reset with three words buffered.
    @(negedge clk);
    check("areset_pre_count", 32'(d3_if.count_o), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", 32'(d3_if.valid_o), 32'd0);
    check("areset_count", 32'(d3_if.count_o), 32'd0);
    check("areset_issue_ready", 32'(d3_if.issue_ready_o), 32'd1);
    check("areset_err", 32'(d3_if.err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("areset_post_valid", 32'(d3_if.valid_o), 32'd0);

    // Single-entry buffer.
    d1_if.ready_i = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wd = (w == 0) ? 8'hA5 : 8'h5A;
      @(posedge clk); #1;
      n = 0;
      while (!d1_if.issue_ready_o && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check("single_issue_ready", 32'(d1_if.issue_ready_o), 32'd1);
      d1_if.issue_i = 1'b1;
      d1_src = wd;
      @(posedge clk); #1;
      d1_if.issue_i = 1'b0;
      @(negedge clk);
      check("single_busy", 32'(d1_if.issue_ready_o), 32'd0);
      n = 0;
      while (!d1_if.valid_o && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("single_valid", 32'(d1_if.valid_o), 32'd1);
      check("single_data", 32'(d1_if.data_o), 32'(wd));
      check("single_count", 32'(d1_if.count_o), 32'd1);
    end
    @(negedge clk);
    check("single_empty", 32'(d1_if.count_o), 32'd0);
    check("single_err", 32'(d1_if.err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
